// File: rtl/ring_counter_pkg.sv
// ---------------------------------------------------------------------------
// ring_counter_pkg
// Shared definitions for the ring / Johnson sequence generator.
//   mode_e            : counter mode (one-hot ring or Johnson twisted ring)
//   width_mask()      : mask with the low 'width' bits set
//   seed()            : seed state of a mode, masked to 'width' bits
//   is_legal_ring()   : exactly one bit set within 'width' bits
//   is_legal_johnson(): at most two value boundaries around the circle
// States are passed zero-extended to MAX_W bits so one set of helpers
// serves every legal WIDTH.
// ---------------------------------------------------------------------------
package ring_counter_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    function automatic logic [MAX_W-1:0] width_mask(input int width);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] seed(input mode_e mode, input int width);
        logic [MAX_W-1:0] s;
        s = (mode == MODE_RING) ? MAX_W'(1) : '0;
        return s & width_mask(width);
    endfunction

    function automatic logic is_legal_ring(input logic [MAX_W-1:0] v, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && v[i]) ones++;
        end
        return (ones == 1);
    endfunction

    // Count neighbour pairs that differ, including the MSB->bit0 wrap.
    // A Johnson-shaped state has a single run of ones on the circle, so it
    // shows either zero boundaries (all-0 / all-1) or exactly two.
    function automatic logic is_legal_johnson(input logic [MAX_W-1:0] v, input int width);
        int edges;
        int j;
        edges = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                j = (i + 1 == width) ? 0 : i + 1;
                if (v[i] != v[j]) edges++;
            end
        end
        return (edges <= 2);
    endfunction

endpackage

// File: rtl/ring_counter_gen_pos_encode.sv
// ---------------------------------------------------------------------------
// ring_pos_encode
// Combinational state-to-index encoder. The index is the position of the
// state in the up-counting sequence of the given mode.
//   state : counter state (WIDTH bits)
//   mode  : MODE_RING or MODE_JOHNSON
//   pos   : up-sequence index (POS_W bits)
// Ring    : index of the set bit.
// Johnson : popcount while the MSB is 0 (filling phase), otherwise
//           WIDTH + number of zeros (draining phase).
// ---------------------------------------------------------------------------
module ring_pos_encode
    import ring_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int POS_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] state,
    input  mode_e            mode,
    output logic [POS_W-1:0] pos
);

    int ones;
    int ring_idx;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        ones     = 0;
        ring_idx = 0;
        pos      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (state[i]) begin
                ones++;
                ring_idx = i;
            end
        end
        if (mode == MODE_RING) begin
            pos = POS_W'(ring_idx);
        end else if (!state[WIDTH-1]) begin
            pos = POS_W'(ones);
        end else begin
            pos = POS_W'(2 * WIDTH - ones);
        end
    end

endmodule

// File: rtl/ring_counter_gen.sv
// ---------------------------------------------------------------------------
// ring_counter_gen
// Parametrised phase/sequence generator: one-hot ring or Johnson counter,
// selectable at run time, with enable, direction, parallel load, illegal
// state detection with self-recovery, a position index and a wrap pulse.
// Ports:
//   Clock      : rising-edge clock
//   Reset      : synchronous, active-high reset
//   Enable     : advance one step this cycle
//   Dir        : 0 = up (toward MSB), 1 = down
//   Mode       : 0 = ring, 1 = Johnson
//   Load       : parallel load strobe
//   Load_value : value to load (replaced by the seed when illegal)
//   Count_out  : registered counter state
//   Position   : registered up-sequence index of Count_out
//   Wrap       : one-cycle pulse when an enabled step lands on the seed
//   Illegal    : one-cycle pulse when an illegal load or state is corrected
// Per-cycle priority: Reset > Load > mode change > recovery > step > hold.
// ---------------------------------------------------------------------------
module ring_counter_gen
    import ring_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int POS_W = $clog2(2 * WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Dir,
    input  logic             Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    output logic [WIDTH-1:0] Count_out,
    output logic [POS_W-1:0] Position,
    output logic             Wrap,
    output logic             Illegal
);

    logic [WIDTH-1:0] count_q, count_d;
    mode_e            mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic             illegal_q, illegal_d;

    mode_e            mode_req;
    logic [WIDTH-1:0] cur_seed;
    logic [WIDTH-1:0] req_seed;
    logic [WIDTH-1:0] stepped;
    logic             load_ok;
    logic             state_ok;

    function automatic logic state_legal(input logic [WIDTH-1:0] v, input mode_e m);
        return (m == MODE_RING) ? is_legal_ring(MAX_W'(v), WIDTH)
                                : is_legal_johnson(MAX_W'(v), WIDTH);
    endfunction

    // One step of the current mode. The Johnson twist feeds the inverted
    // outgoing bit back in at the other end.
    function automatic logic [WIDTH-1:0] next_step(input logic [WIDTH-1:0] v,
                                                   input mode_e m, input logic down);
        logic [WIDTH-1:0] r;
        if (m == MODE_RING) begin
            r = down ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
        end else begin
            r = down ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
        end
        return r;
    endfunction

    assign mode_req = mode_e'(Mode);
    assign cur_seed = WIDTH'(seed(mode_q, WIDTH));
    assign req_seed = WIDTH'(seed(mode_req, WIDTH));
    assign stepped  = next_step(count_q, mode_q, Dir);
    assign load_ok  = state_legal(Load_value, mode_q);
    assign state_ok = state_legal(count_q, mode_q);

    always_comb begin
        count_d   = count_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        if (Load) begin
            // Legality is judged against the mode already in force; a
            // pending mode change waits until Load is released.
            if (load_ok) begin
                count_d = Load_value;
            end else begin
                count_d   = cur_seed;
                illegal_d = 1'b1;
            end
        end else if (mode_req != mode_q) begin
            mode_d  = mode_req;
            count_d = req_seed;
        end else if (!state_ok) begin
            count_d   = cur_seed;
            illegal_d = 1'b1;
        end else if (Enable) begin
            count_d = stepped;
            wrap_d  = (stepped == cur_seed);
        end
    end

    // Position is encoded from the next state so it lands in the same
    // cycle as Count_out.
    ring_pos_encode #(
        .WIDTH (WIDTH)
    ) u_pos_encode (
        .state (count_d),
        .mode  (mode_d),
        .pos   (pos_d)
    );

    always_ff @(posedge Clock) begin
        // NOTE: the reset is synchronous, so it lives inside the clocked
        // branch and every flop here is plain state, not a memory array.
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from the values before the edge.
            count_q   <= WIDTH'(seed(MODE_RING, WIDTH));
            mode_q    <= MODE_RING;
            pos_q     <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            mode_q    <= mode_d;
            pos_q     <= pos_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign Count_out = count_q;
    assign Position  = pos_q;
    assign Wrap      = wrap_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_ring_counter_gen
// Self-checking bench for ring_counter_gen (WIDTH = 4). Directed sequences
// with literal expectations, then random stimulus compared every cycle with
// an arithmetic reference model of the counter rules.
// ---------------------------------------------------------------------------
module tb_ring_counter_gen;

    localparam int W     = 4;
    localparam int PW    = $clog2(2 * W);
    localparam int MASK  = (1 << W) - 1;

    logic          Clock;
    logic          Reset;
    logic          Enable;
    logic          Dir;
    logic          Mode;
    logic          Load;
    logic [W-1:0]  Load_value;
    logic [W-1:0]  Count_out;
    logic [PW-1:0] Position;
    logic          Wrap;
    logic          Illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: counter value as an integer.
    int m_cnt;
    int m_mode;
    int m_pos;
    int m_wrap;
    int m_ill;

    ring_counter_gen #(
        .WIDTH (W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .Dir        (Dir),
        .Mode       (Mode),
        .Load       (Load),
        .Load_value (Load_value),
        .Count_out  (Count_out),
        .Position   (Position),
        .Wrap       (Wrap),
        .Illegal    (Illegal)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- model helpers: plain integer arithmetic on the state ----
    function automatic int rotl(input int c);
        return ((c << 1) | (c >> (W - 1))) & MASK;
    endfunction

    function automatic int seed_of(input int mode);
        return (mode == 0) ? 1 : 0;
    endfunction

    function automatic bit legal(input int c, input int mode);
        if (mode == 0) return ($countones(c & MASK) == 1);
        return ($countones((c ^ rotl(c)) & MASK) <= 2);
    endfunction

    function automatic int advance(input int c, input int mode, input bit down);
        int msb;
        int lsb;
        msb = (c >> (W - 1)) & 1;
        lsb = c & 1;
        if (mode == 0) begin
            if (!down) return rotl(c);
            return ((c >> 1) | (lsb << (W - 1))) & MASK;
        end
        if (!down) return ((c << 1) & MASK) | (1 - msb);
        return (c >> 1) | ((1 - lsb) << (W - 1));
    endfunction

    function automatic int position_of(input int c, input int mode);
        int ones;
        ones = $countones(c & MASK);
        if (mode == 0) return $clog2(c);
        if (((c >> (W - 1)) & 1) == 0) return ones;
        return W + (W - ones);
    endfunction

    task automatic model_update();
        if (Reset) begin
            m_cnt  = 1;
            m_mode = 0;
            m_wrap = 0;
            m_ill  = 0;
        end else begin
            m_wrap = 0;
            m_ill  = 0;
            if (Load) begin
                if (legal(int'(Load_value), m_mode)) begin
                    m_cnt = int'(Load_value);
                end else begin
                    m_cnt = seed_of(m_mode);
                    m_ill = 1;
                end
            end else if (int'(Mode) != m_mode) begin
                m_mode = int'(Mode);
                m_cnt  = seed_of(m_mode);
            end else if (!legal(m_cnt, m_mode)) begin
                m_cnt = seed_of(m_mode);
                m_ill = 1;
            end else if (Enable) begin
                m_cnt  = advance(m_cnt, m_mode, Dir);
                m_wrap = (m_cnt == seed_of(m_mode)) ? 1 : 0;
            end
        end
        m_pos = position_of(m_cnt, m_mode);
    endtask

    // One clock: the model follows the inputs sampled at the edge, outputs
    // are compared 1 ns later.
    task automatic tick();
        @(posedge Clock);
        model_update();
        #1;
        check("count",   32'(Count_out), 32'(m_cnt));
        check("pos",     32'(Position),  32'(m_pos));
        check("wrap",    32'(Wrap),      32'(m_wrap));
        check("illegal", 32'(Illegal),   32'(m_ill));
    endtask

    int exp1 [5] = '{2, 4, 8, 1, 2};
    int exp2 [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    int exp3 [4] = '{8, 4, 2, 1};

    initial begin
        m_cnt = 0; m_mode = 0; m_pos = 0; m_wrap = 0; m_ill = 0;
        Reset = 1'b1; Enable = 1'b1; Dir = 1'b0; Mode = 1'b0;
        Load = 1'b0; Load_value = '0;

        // 1: reset, then ring up with a wrap.
        repeat (3) tick();
        check("t1_reset_count", 32'(Count_out), 32'd1);
        check("t1_reset_pos",   32'(Position),  32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_count", 32'(Count_out), 32'(exp1[i]));
            check("t1_wrap",  32'(Wrap),      32'(i == 3));
        end

        // 2: switch to Johnson at 0100, then a full up period.
        tick();
        check("t2_pre", 32'(Count_out), 32'd4);
        Mode = 1'b1;
        tick();
        check("t2_seed", 32'(Count_out), 32'd0);
        check("t2_seed_wrap", 32'(Wrap), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_count", 32'(Count_out), 32'(exp2[i]));
            check("t2_pos",   32'(Position),  32'((i + 1) % 8));
            check("t2_wrap",  32'(Wrap),      32'(i == 7));
        end

        // 3: ring, counting down.
        Mode = 1'b0;
        tick();
        check("t3_seed", 32'(Count_out), 32'd1);
        Dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_count", 32'(Count_out), 32'(exp3[i]));
            check("t3_wrap",  32'(Wrap),      32'(i == 3));
        end

        // 4: ring loads, illegal then legal.
        Enable = 1'b0; Dir = 1'b0;
        Load = 1'b1; Load_value = 4'b0110;
        tick();
        check("t4_bad_count", 32'(Count_out), 32'd1);
        check("t4_bad_ill",   32'(Illegal),   32'd1);
        Load_value = 4'b0100;
        tick();
        check("t4_ok_count", 32'(Count_out), 32'd4);
        check("t4_ok_pos",   32'(Position),  32'd2);
        check("t4_ok_ill",   32'(Illegal),   32'd0);
        Load = 1'b0;

        // 5: Johnson loads, then a held corrupt state recovered.
        Mode = 1'b1;
        tick();
        check("t5_seed", 32'(Count_out), 32'd0);
        Load = 1'b1; Load_value = 4'b0101;
        tick();
        check("t5_bad_count", 32'(Count_out), 32'd0);
        check("t5_bad_ill",   32'(Illegal),   32'd1);
        Load_value = 4'b1100;
        tick();
        check("t5_ok_count", 32'(Count_out), 32'd12);
        check("t5_ok_pos",   32'(Position),  32'd6);
        Load_value = 4'b0110;
        tick();
        Load = 1'b0; Enable = 1'b1;
        tick();
        check("t5_step1", 32'(Count_out), 32'd13);
        tick();
        check("t5_step2", 32'(Count_out), 32'd10);
        Enable = 1'b0;
        tick();
        check("t5_recover",     32'(Count_out), 32'd0);
        check("t5_recover_ill", 32'(Illegal),   32'd1);

        // 6: reset beats load and enable, then hold.
        Mode = 1'b0; Enable = 1'b1;
        tick();
        repeat (3) tick();
        check("t6_pre", 32'(Count_out), 32'd8);
        Reset = 1'b1; Load = 1'b1; Load_value = 4'b0100;
        tick();
        check("t6_reset", 32'(Count_out), 32'd1);
        Reset = 1'b0; Load = 1'b0; Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold",      32'(Count_out), 32'd1);
            check("t6_hold_wrap", 32'(Wrap),      32'd0);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r          = int'($urandom_range(0, 99));
            Reset      = (r < 2);
            Load       = (r >= 2 && r < 10);
            if (r >= 10 && r < 14) Mode = ~Mode;
            Enable     = ($urandom_range(0, 3) != 0);
            Dir        = 1'($urandom);
            Load_value = W'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_counter_gen.md
Name: ring_counter_gen

Overview:
Parametrised successor to the fixed 4-bit ring counter. It supports two runtime modes: one-hot ring and Johnson (twisted ring). It adds count enable, direction, parallel load, illegal-state detection with self-recovery, a binary position output and a wrap pulse. It is used as a phase/sequence generator in place of the hard-coded 4-bit ring counter.

Parameters:
WIDTH, 4, number of flops in Count_out; legal range 2..32.
POS_W, $clog2(2*WIDTH), width of Position; derived, not overridden.

Ports:
Clock  in  1  single clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Enable  in  1  advance one step per cycle when high.
Dir  in  1  0 = up (rotate/shift toward MSB), 1 = down.
Mode  in  1  0 = ring (one-hot), 1 = Johnson.
Load  in  1  parallel load strobe.
Load_value  in  WIDTH  value for Load.
Count_out  out  WIDTH  registered counter state.
Position  out  POS_W  registered step index of Count_out.
Wrap  out  1  registered one-cycle pulse when a step lands on the seed.
Illegal  out  1  registered one-cycle pulse when an illegal state or load is corrected.

Behaviour:
- Seeds:
  - Ring seed = 0...01.
  - Johnson seed = all zeros.
- Reset (synchronous, active-high):
  - Count_out = ring seed (0001 for WIDTH=4).
  - Internal mode register = ring.
  - Position = 0, Wrap = 0, Illegal = 0.
- Priority per cycle: Reset > Load > mode change > illegal recovery > Enable step > hold.
- Load:
  - If Load_value is legal for the current mode, Count_out = Load_value.
  - Otherwise Count_out = seed of the current mode and Illegal = 1.
  - Wrap = 0 on any load.
- Mode change: when Mode differs from the internal mode register:
  - The register updates to Mode.
  - Count_out = seed of the new mode.
  - Wrap = 0, Illegal = 0.
  - Enable is ignored that cycle.
- Legality:
  - Ring: Count_out is exactly one-hot.
  - Johnson: bits form at most one 0/1 boundary and one 1/0 boundary around the circle; all-zeros and all-ones are legal.
- Recovery: if the held state is illegal (SEU, X-free corruption), the next cycle gives Count_out = seed and Illegal = 1, regardless of Enable.
- Ring step:
  - Up: rotate left (bit i goes to bit i+1; MSB goes to bit0).
  - Down: rotate right.
- Johnson step:
  - Up: shift left, bit0 = ~MSB.
  - Down: shift right, MSB = ~bit0.
  - Period is 2*WIDTH states; up sequence for WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Position, updated in the same cycle as Count_out with no extra latency:
  - Ring: index of the set bit.
  - Johnson: if MSB = 0, popcount; else WIDTH + number of zeros.
  - The index is always the up-sequence index, independent of Dir.
- Wrap: 1 for exactly one cycle when an Enable step (either direction) produces the seed; 0 for reset, load, recovery or mode change.
- Enable = 0: all state held; Wrap and Illegal return to 0.
- Direction change takes effect on the next step with no bubble.

Decomposition:
- Shared package ring_counter_pkg holds:
  - mode enum (MODE_RING = 0, MODE_JOHNSON = 1);
  - function seed(mode, WIDTH);
  - functions is_legal_ring and is_legal_johnson.
- One sub-module, ring_pos_encode: purely combinational state-to-Position encoder, parametrised on WIDTH, instantiated once and registered in the parent.

Test Plan:
1. Reset high 3 cycles, then Enable=1, Dir=0, Mode=0 for 5 cycles -> Count_out 0001 after reset, then 0010, 0100, 1000, 0001 (Wrap=1, Position=0), 0010; Illegal stays 0.
2. Mode=1 (at Count_out=0100) -> next cycle 0000, Position=0, Wrap=0. Then 8 up steps -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; Position 1..7 then 0; Wrap=1 only on the 8th step.
3. Ring mode from 0001, Dir=1, 4 steps -> 1000 (Position 3), 0100, 0010, 0001 (Wrap=1).
4. Ring mode Load=1, Load_value=0110 -> Count_out=0001, Illegal=1 for one cycle. Then Load_value=0100 -> Count_out=0100, Position=2, Illegal=0.
5. Johnson mode Load_value=0101 -> Count_out=0000, Illegal=1. Load_value=1100 -> Count_out=1100, Position=6.
6. Reset, Load and Enable high together at Count_out=1000 -> Count_out=0001, mode=ring. Then Enable=0 for 3 cycles -> Count_out holds 0001 and Wrap stays 0.
